// File: rtl/inst_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// inst_prefetch_buffer: circular RVC halfword fetch buffer, credit-based line
// prefetch, one 16/32-bit instruction per cycle to decode.
// Option macro INST_PREFETCH_BYPASS_EN: same-cycle bypass into an empty buffer.
// Revision: 1.0
// ============================================================================
module inst_prefetch_buffer #(
   parameter int LINEWIDTH       = 64,
   parameter int DEPTH           = 16,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [$clog2(LINEWIDTH/16)-1:0]  flush_offset,
   output logic                             req_valid,
   input  logic                             req_ready,
   input  logic                             rsp_valid,
   input  logic [LINEWIDTH-1:0]             rsp_data,
   output logic                             inst_valid,
   input  logic                             inst_ready,
   output logic [31:0]                      inst_out,
   output logic                             inst_rvc
);
   localparam int EPL = LINEWIDTH / 16;
   localparam int OW  = $clog2(EPL);
   localparam int PW  = $clog2(DEPTH);
   localparam int FW  = PW + 1;
   localparam int CW  = 3;

   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [CW-1:0] pend_q, pend_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [OW-1:0] skip_q, skip_d;

   logic [15:0]   line_hw [EPL];
   logic [15:0]   buf_h0, buf_h1, cur_h0, cur_h1;
   logic          buf_rvc, buf_valid, cur_rvc, byp;
   logic          wr_en, pop, fire, req_ok;
   logic [1:0]    pop_n;

   always_comb begin
      for (int i = 0; i < EPL; i++) begin
         line_hw[i] = rsp_data[16*i +: 16];
      end
   end

   // Both halves are read modulo DEPTH so an instruction may straddle the wrap.
   assign buf_h0    = mem_q[rd_ptr_q];
   assign buf_h1    = mem_q[rd_ptr_q + PW'(1)];
   assign buf_rvc   = buf_h0[1:0] != 2'b11;
   assign buf_valid = (fill_q >= FW'(2)) || ((fill_q == FW'(1)) && buf_rvc);
   assign wr_en     = rsp_valid && !flush && (drop_q == '0) && (pend_q != '0);

`ifdef INST_PREFETCH_BYPASS_EN
   logic [15:0] byp_h0, byp_h1;
   logic        byp_rvc;

   // A 32-bit instruction whose upper half would lie past the line end waits for the buffer.
   assign byp_h0  = line_hw[skip_q];
   assign byp_h1  = line_hw[skip_q + OW'(1)];
   assign byp_rvc = byp_h0[1:0] != 2'b11;
   assign byp     = wr_en && (fill_q == '0) && inst_ready &&
                    (byp_rvc || (skip_q != OW'(EPL - 1)));
   assign cur_h0  = byp ? byp_h0 : buf_h0;
   assign cur_h1  = byp ? byp_h1 : buf_h1;
`else
   assign byp     = 1'b0;
   assign cur_h0  = buf_h0;
   assign cur_h1  = buf_h1;
`endif

   assign cur_rvc    = cur_h0[1:0] != 2'b11;
   assign inst_valid = rst && (buf_valid || byp);
   assign inst_rvc   = inst_valid && cur_rvc;
   assign inst_out   = !inst_valid ? 32'h0 :
                       cur_rvc     ? {16'h0, cur_h0} : {cur_h1, cur_h0};
   assign pop        = inst_valid && inst_ready && !flush;
   assign pop_n      = cur_rvc ? 2'd1 : 2'd2;

   // Space is reserved for every live request so accepted lines always fit.
   assign req_ok    = ((int'(pend_q) + int'(drop_q)) < MAX_OUTSTANDING) &&
                      ((int'(fill_q) + (int'(pend_q) + 1) * EPL) <= DEPTH);
   assign req_valid = rst && !flush && req_ok;
   assign fire      = req_valid && req_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      pend_d   = pend_q;
      drop_d   = drop_q;
      skip_d   = skip_q;
      if (flush) begin
         rd_ptr_d = PW'(flush_offset);
         wr_ptr_d = '0;
         fill_d   = '0;
         pend_d   = '0;
         skip_d   = flush_offset;
         drop_d   = drop_q + pend_q;
         if (rsp_valid && (drop_d != '0)) begin
            drop_d = drop_d - CW'(1);
         end
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(EPL);
            skip_d   = '0;
         end
         if (rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         pend_d = pend_q + CW'(fire) - CW'(wr_en);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
         end
         fill_d = fill_q + (wr_en ? (FW'(EPL) - FW'(skip_q)) : '0)
                         - (pop ? FW'(pop_n) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         pend_q   <= '0;
         drop_q   <= '0;
         skip_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         pend_q   <= pend_d;
         drop_q   <= drop_d;
         skip_q   <= skip_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < EPL; i++) begin
            mem_q[wr_ptr_q + PW'(i)] <= line_hw[i];
         end
      end
   end

   a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst)
      rsp_valid |-> ((pend_q != '0) || (drop_q != '0)));
   a_fill_bound: assert property (@(posedge clk) disable iff (!rst)
      int'(fill_q) <= DEPTH);
   a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
      (int'(pend_q) + int'(drop_q)) <= MAX_OUTSTANDING);

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// tb_inst_prefetch_buffer: scoreboard bench with a halfword-stream reference.
// Revision: 1.0
// ============================================================================
module tb_inst_prefetch_buffer;
   localparam int LW    = 64;
   localparam int DEPTH = 16;
   localparam int MAXO  = 2;
   localparam int EPL   = LW / 16;
   localparam int OW    = $clog2(EPL);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic [OW-1:0] flush_offset = '0;
   logic          req_valid;
   logic          req_ready = 1'b0;
   logic          rsp_valid = 1'b0;
   logic [LW-1:0] rsp_data = '0;
   logic          inst_valid;
   logic          inst_ready = 1'b0;
   logic [31:0]   inst_out;
   logic          inst_rvc;

   inst_prefetch_buffer #(
      .LINEWIDTH      (LW),
      .DEPTH          (DEPTH),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .flush_offset(flush_offset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_rvc    (inst_rvc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      bit          rvc;
   } exp_t;

   // Reference: outstanding requests (1 = live, 0 = stale), unparsed halfwords, parsed instructions.
   exp_t          exp_q[$];
   logic [15:0]   hw_q[$];
   bit            live_q[$];
   logic [LW-1:0] line_q[$];
   int            skip_m = 0;

   int checks = 0;
   int errors = 0;
   bit exp_req = 1'b0;
   bit pop_seen = 1'b0;
   bit fire_seen = 1'b0;
   bit mon_en = 1'b0;
   bit rst_chk = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      pop_seen  = 1'b0;
      fire_seen = 1'b0;
      if (!rst) begin
         if (rst_chk) begin
            chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
            chk("rst_inst_out", inst_out, 32'h0);
            chk("rst_inst_rvc", {31'b0, inst_rvc}, 32'h0);
         end
      end else if (mon_en) begin
         fire_seen = req_valid && req_ready;
         chk("req_valid", {31'b0, req_valid}, {31'b0, exp_req});
         if (exp_q.size() > 0) begin
            chk("inst_valid", {31'b0, inst_valid}, 32'h1);
            chk("inst_out", inst_out, exp_q[0].ins);
            chk("inst_rvc", {31'b0, inst_rvc}, {31'b0, exp_q[0].rvc});
            pop_seen = inst_valid && inst_ready && !flush;
         end else begin
            chk("inst_idle_valid", {31'b0, inst_valid}, 32'h0);
            chk("inst_idle_out", inst_out, 32'h0);
         end
      end
   end

   function automatic int model_fill();
      int n = hw_q.size();
      foreach (exp_q[i]) n += exp_q[i].rvc ? 1 : 2;
      return n;
   endfunction

   function automatic int live_cnt();
      int n = 0;
      foreach (live_q[i]) if (live_q[i]) n++;
      return n;
   endfunction

   task automatic parse();
      bit more = 1'b1;
      exp_t e;
      while (more) begin
         if (hw_q.size() > 0 && hw_q[0][1:0] != 2'b11) begin
            e.ins = {16'h0, hw_q[0]};
            e.rvc = 1'b1;
            exp_q.push_back(e);
            void'(hw_q.pop_front());
         end else if (hw_q.size() >= 2) begin
            e.ins = {hw_q[1], hw_q[0]};
            e.rvc = 1'b0;
            exp_q.push_back(e);
            void'(hw_q.pop_front());
            void'(hw_q.pop_front());
         end else begin
            more = 1'b0;
         end
      end
   endtask

   task automatic apply(input bit f, input int off, input bit rv, input logic [LW-1:0] d);
      bit l;
      if (pop_seen && exp_q.size() > 0) void'(exp_q.pop_front());
      if (f) begin
         if (rv && live_q.size() > 0) void'(live_q.pop_front());
         foreach (live_q[i]) live_q[i] = 1'b0;
         hw_q.delete();
         exp_q.delete();
         skip_m = off;
      end else begin
         if (rv && live_q.size() > 0) begin
            l = live_q.pop_front();
            if (l) begin
               for (int i = skip_m; i < EPL; i++) hw_q.push_back(d[16*i +: 16]);
               skip_m = 0;
               parse();
            end
         end
         if (fire_seen) live_q.push_back(1'b1);
      end
   endtask

   task automatic cycle(input bit f, input int off, input bit rr, input bit rv,
                        input logic [LW-1:0] d, input bit ir);
      flush        = f;
      flush_offset = OW'(off);
      req_ready    = rr;
      rsp_valid    = rv;
      rsp_data     = d;
      inst_ready   = ir;
      exp_req      = !f && (live_q.size() < MAXO) &&
                     (DEPTH - model_fill() - live_cnt() * EPL >= EPL);
      @(posedge clk);
      #1;
      apply(f, off, rv, d);
   endtask

   // Answers every outstanding request at once, taking data from line_q first.
   task automatic run_auto(input int n, input bit rr, input bit ir, input logic [LW-1:0] dflt);
      bit            rv;
      logic [LW-1:0] d;
      for (int k = 0; k < n; k++) begin
         rv = live_q.size() > 0;
         d  = dflt;
         if (rv && line_q.size() > 0) d = line_q.pop_front();
         cycle(1'b0, 0, rr, rv, d, ir);
      end
   endtask

   function automatic logic [LW-1:0] gen_line();
      logic [LW-1:0] l;
      logic [15:0]   h;
      for (int i = 0; i < EPL; i++) begin
         h = 16'($urandom);
         if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
         else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
         l[16*i +: 16] = h;
      end
      return l;
   endfunction

   initial begin
      bit f, rr, rv, ir;
      int off;

      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b1;
      rst_chk = 1'b0;
      mon_en  = 1'b1;

      // Single line, three RVC instructions then a lone 32-bit lower half.
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
      cycle(1'b0, 0, 1'b0, 1'b1, 64'h0013_0001_4501_4581, 1'b1);
      run_auto(6, 1'b0, 1'b1, '0);
      cycle(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

      // Fill to capacity with decode stalled, then release two 32-bit pops.
      run_auto(12, 1'b1, 1'b0, 64'h0000_0013_0000_0013);
      cycle(1'b0, 0, 1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 0, 1'b0, 1'b0, '0, 1'b1);
      run_auto(2, 1'b0, 1'b0, '0);
      cycle(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
      run_auto(3, 1'b0, 1'b0, '0);

      // 32-bit instruction straddling halfwords 15 and 0.
      line_q.push_back(64'h0001_0001_0001_0001);
      line_q.push_back(64'h0001_0001_0001_0001);
      line_q.push_back(64'h0001_0001_0001_0001);
      line_q.push_back(64'h0093_0001_0001_0001);
      line_q.push_back(64'h0001_0001_0001_00A0);
      run_auto(20, 1'b1, 1'b1, 64'h0001_0001_0001_0001);
      cycle(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
      run_auto(3, 1'b0, 1'b0, '0);

      // Flush with two requests in flight and a non-zero start offset.
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 2, 1'b0, 1'b0, '0, 1'b1);
      run_auto(10, 1'b1, 1'b1, 64'h0000_0000_8082_1111);
      cycle(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
      run_auto(3, 1'b0, 1'b0, '0);

      // Flush coinciding with the only live response.
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 0, 1'b0, 1'b1, gen_line(), 1'b1);
      run_auto(3, 1'b0, 1'b1, '0);

      // Randomized traffic with alternating decode-pressure phases.
      for (int k = 0; k < 3000; k++) begin
         f   = $urandom_range(0, 59) == 0;
         off = $urandom_range(0, EPL - 1);
         rr  = $urandom_range(0, 3) != 0;
         rv  = (live_q.size() > 0) && ($urandom_range(0, 2) != 0);
         ir  = ((k / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle(f, off, rr, rv, gen_line(), ir);
      end

      // Asynchronous reset with two requests outstanding and an instruction presented.
      cycle(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
      run_auto(3, 1'b0, 1'b0, '0);
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b1, 64'h0001_0001_0001_0001, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, '0, 1'b0);
      req_ready = 1'b0;
      rst_chk   = 1'b1;
      rst       = 1'b0;
      @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
